// File: rtl/decode_stage.sv
// decode_stage: second pipeline stage. Holds the fetched instruction in D,
// resolves JMP/JZ, detects load-use hazards and HLT, and presents a
// registered decoded instruction to execute through the E register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic [15:0] current_address,
    input  logic [15:0] pc_in,
    input  logic        zero_flag,
    input  logic        ex_stall,
    output logic        stall,
    output logic        stall_pm,
    output logic        pc_mux_sel,
    output logic [15:0] jmp_loc,
    output logic        ex_valid,
    output logic [4:0]  ex_opcode,
    output logic [2:0]  ex_rd,
    output logic [2:0]  ex_rs1,
    output logic [2:0]  ex_rs2,
    output logic [15:0] ex_imm,
    output logic [15:0] ex_pc,
    output logic        halted
);

    localparam logic [4:0] OP_LOAD  = 5'd8;
    localparam logic [4:0] OP_STORE = 5'd9;
    localparam logic [4:0] OP_JMP   = 5'd10;
    localparam logic [4:0] OP_JZ    = 5'd11;
    localparam logic [4:0] OP_HLT   = 5'd31;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    // Decoded instruction as seen by execute; all-zero is a bubble.
    typedef struct packed {
        logic        valid;
        logic [4:0]  opcode;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic [15:0] pc;
    } ex_t;

    // ALU ops and LOAD/STORE read rs1.
    function automatic logic reads_rs1(input logic [4:0] op);
        return (op >= 5'd1) && (op <= OP_STORE);
    endfunction

    // ALU ops and STORE read rs2.
    function automatic logic reads_rs2(input logic [4:0] op);
        return ((op >= 5'd1) && (op <= 5'd7)) || (op == OP_STORE);
    endfunction

    state_t      state_q, state_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_ins_q, d_ins_d;
    logic [15:0] d_pc_q, d_pc_d;
    ex_t         e_q, e_d;
    ex_t         d_as_ex;

    logic [4:0]  d_op;
    logic [2:0]  d_rd;
    logic [4:0]  in_op;
    logic        d_is_hlt;
    logic        jump_taken;
    logic        load_use;
    logic        unused_inputs;

    // The fetch address only matters to fetch; the two pad bits of D are never decoded.
    assign unused_inputs = ^{current_address, d_ins_q[17:16]};

    assign d_op  = d_ins_q[31:27];
    assign d_rd  = d_ins_q[26:24];
    assign in_op = ins[31:27];

    assign d_is_hlt   = d_valid_q && (d_op == OP_HLT);
    assign jump_taken = d_valid_q && ((d_op == OP_JMP) || ((d_op == OP_JZ) && zero_flag));
    assign load_use   = d_valid_q && (d_op == OP_LOAD) &&
                        ((reads_rs1(in_op) && (ins[23:21] == d_rd)) ||
                         (reads_rs2(in_op) && (ins[20:18] == d_rd)));

    assign d_as_ex = '{valid:  d_valid_q,
                       opcode: d_op,
                       rd:     d_rd,
                       rs1:    d_ins_q[23:21],
                       rs2:    d_ins_q[20:18],
                       imm:    d_ins_q[15:0],
                       pc:     d_pc_q};

    // Per-cycle priority: HALT, execute freeze, HLT entry, taken jump, load-use, advance.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stall      = 1'b0;
        stall_pm   = 1'b0;
        pc_mux_sel = 1'b0;
        state_d    = state_q;
        d_valid_d  = d_valid_q;
        d_ins_d    = d_ins_q;
        d_pc_d     = d_pc_q;
        e_d        = e_q;

        if (state_q == ST_HALT) begin
            stall    = 1'b1;
            stall_pm = 1'b1;
        end else if (ex_stall) begin
            stall    = 1'b1;
            stall_pm = 1'b1;
        end else if (d_is_hlt) begin
            stall     = 1'b1;
            stall_pm  = 1'b1;
            state_d   = ST_HALT;
            d_valid_d = 1'b0;
            d_ins_d   = '0;
            d_pc_d    = '0;
            e_d       = '0;
        end else begin
            e_d = d_as_ex;
            if (jump_taken || load_use) begin
                // Squash the wrong-path ins, or leave it for fetch to re-present.
                pc_mux_sel = jump_taken;
                stall      = !jump_taken;
                stall_pm   = !jump_taken;
                d_valid_d  = 1'b0;
                d_ins_d    = '0;
                d_pc_d     = '0;
            end else begin
                d_valid_d = 1'b1;
                d_ins_d   = ins;
                d_pc_d    = pc_in;
            end
        end
    end

    // State, D and E registers; reset clears everything to a bubble in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            d_valid_q <= 1'b0;
            d_ins_q   <= '0;
            d_pc_q    <= '0;
            e_q       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the values from before this edge.
            state_q   <= state_d;
            d_valid_q <= d_valid_d;
            d_ins_q   <= d_ins_d;
            d_pc_q    <= d_pc_d;
            e_q       <= e_d;
        end
    end

    assign jmp_loc   = d_ins_q[15:0];
    assign halted    = (state_q == ST_HALT);
    assign ex_valid  = e_q.valid;
    assign ex_opcode = e_q.opcode;
    assign ex_rd     = e_q.rd;
    assign ex_rs1    = e_q.rs1;
    assign ex_rs2    = e_q.rs2;
    assign ex_imm    = e_q.imm;
    assign ex_pc     = e_q.pc;

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage, directly downstream of `program_memory`. Captures the fetched 32-bit instruction and its address, decodes fields, and resolves `JMP`/`JZ` in decode. Detects load-use hazards and halt, and drives `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc` back to fetch. Presents a registered, decoded instruction to the execute stage.

## Interface
Parameters:
- none; all widths fixed: 32-bit instruction, 16-bit address, 3-bit register index.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; the block is held in reset while 0
- `ins`  in  32  instruction from fetch; belongs to the address fetch presented in the previous cycle
- `current_address`  in  16  fetch address driven in this cycle; not used for decode
- `pc_in`  in  16  address of `ins`, supplied by fetch
- `zero_flag`  in  1  ALU zero flag, sampled in the cycle `JZ` sits in D
- `ex_stall`  in  1  execute is busy; freeze D and E
- `stall`  out  1  to fetch: hold the address
- `stall_pm`  out  1  to fetch: re-present the previous instruction
- `pc_mux_sel`  out  1  to fetch: select `jmp_loc`
- `jmp_loc`  out  16  jump target; equals D.imm16
- `ex_valid`  out  1  E holds a real instruction
- `ex_opcode`  out  5  opcode of the instruction in E
- `ex_rd`, `ex_rs1`, `ex_rs2`  out  3 each  register indices of the instruction in E
- `ex_imm`  out  16  immediate of the instruction in E
- `ex_pc`  out  16  address of the instruction in E
- `halted`  out  1  FSM is in HALT

## Operation
Instruction format:
- `[31:27]` opcode
- `[26:24]` rd
- `[23:21]` rs1
- `[20:18]` rs2
- `[15:0]` imm16

Opcodes and the source registers each one reads:
- 0 NOP: none
- 1–7 ALU: rs1, rs2
- 8 LOAD: rs1
- 9 STORE: rs1, rs2
- 10 JMP: none
- 11 JZ: none
- 31 HLT: none
- All other opcodes: treated as NOP, but the valid bit still propagates.

Registers:
- D register: {d_valid, d_ins, d_pc}.
- E register: the `ex_*` outputs.
- Bubble: valid=0 and all fields 0.

Jump taken:
- Condition: d_valid, and either D=JMP, or D=JZ with `zero_flag`=1.
- `pc_mux_sel`=1 and `jmp_loc`=D.imm16 in that cycle.

Load-use hazard:
- Condition: d_valid, D=LOAD, and the incoming `ins` reads a source register equal to D.rd.
- Applies only to source registers the incoming opcode actually reads (see opcode list).

FSM states are RUN and HALT. Per-cycle priority in RUN, highest first:
1. `ex_stall`=1: D and E hold; `stall`=`stall_pm`=1; `pc_mux_sel`=0.
2. D=HLT (valid): E<=bubble, D<=bubble, next state HALT. `stall`=`stall_pm`=1 this cycle.
3. Jump taken: E<=D, D<=bubble (squashes the wrong-path `ins`). `stall`=`stall_pm`=0. The hazard check is suppressed.
4. Load-use hazard: E<=D, D<=bubble, `ins` not captured; `stall`=`stall_pm`=1 for exactly one cycle. Fetch re-presents the same `ins` next cycle, and the hazard is then clear.
5. Otherwise: E<=D, D<={1, `ins`, `pc_in`}.

HALT state:
- `stall`=`stall_pm`=1 and `halted`=1.
- D and E hold bubbles; `pc_mux_sel`=0.
- The only exit is `reset`=0.

## Timing
- All registers reset asynchronously to 0 and FSM=RUN. Reset values: every `ex_*`=0, `halted`=0, `jmp_loc`=0, `stall`=`stall_pm`=`pc_mux_sel`=0.
- Reset mid-operation discards D, E and HALT immediately. The first clock after release captures the instruction at address 0.
- Latency: `ins` captured at edge N appears on `ex_*` after edge N+1.
- `stall`, `stall_pm` and `pc_mux_sel` are combinational from {FSM, D, `ins`, `zero_flag`, `ex_stall`}. They must not depend on `current_address`, because `current_address` depends on them.
- `pc_mux_sel` is asserted for exactly one cycle per taken jump, because D becomes a bubble at the next edge.
- Taken-jump penalty: one squashed slot. The instruction at the target arrives on `ins` in the cycle after `pc_mux_sel`=1.
- JMP directly after LOAD: no hazard, since JMP reads no source registers.
- LOAD followed by a consumer whose rd and rs match only in fields it does not read: no stall.
- `ex_stall` arriving in the same cycle as a hazard or taken jump wins: everything freezes, and the event is re-evaluated when `ex_stall` drops.

## Test plan
- Reset release, PM holds NOP, ALU(op1, rd=2), ALU at addresses 0,1,2 -> `ex_pc` = 0,1,2 on consecutive cycles starting two edges after release; `stall` stays 0.
- `JMP 0x0040` at address 5 -> `pc_mux_sel`=1 and `jmp_loc`=0x0040 for one cycle; the instruction at address 6 never appears with `ex_valid`=1; the next valid `ex_pc`=0x0040.
- `JZ 0x0010` executed once with `zero_flag`=0 and once with `zero_flag`=1 -> not taken: no `pc_mux_sel` and sequential flow. Taken: redirect to 0x0010.
- `LOAD rd=3` followed by `ALU rs2=3` -> `stall`=`stall_pm`=1 for exactly one cycle; `ex_valid` shows 1,0,1; the ALU instruction is issued once.
- `HLT` at address 9 -> `halted`=1 and `stall`=1 persist for over 20 cycles with `ex_valid`=0; pulsing `reset` low clears them and fetch restarts at 0.
- `ex_stall` held high for 3 cycles while D=JMP -> `pc_mux_sel` stays 0 during the freeze, then pulses once after release; `ex_*` unchanged throughout the freeze.
